// File: rtl/unum4_pack_stream_if.sv
// Stream bundle for the unum4 pack unit: unpacked beats in, packed words out.
interface unum4_pack_stream_if #(
  parameter int DATA_W    = 32,
  parameter int EXP_MAX_W = 16,
  parameter int MAN_MAX_W = 29,
  parameter int EXTRA     = 3,
  parameter int TAG_W     = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [EXP_MAX_W-1:0]         in_exp;
  logic [MAN_MAX_W+EXTRA-1:0]   in_mant;
  logic [1:0]                   in_rmode;
  logic [TAG_W-1:0]             in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_data;
  logic [TAG_W-1:0]             out_tag;
  logic                         out_overflow;
  logic                         out_underflow;
  logic                         out_inexact;

  // Producer of unpacked beats and consumer of packed words
  modport master (
    output in_valid, in_exp, in_mant, in_rmode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag,
           out_overflow, out_underflow, out_inexact
  );

  // The pack unit itself
  modport slave (
    input  in_valid, in_exp, in_mant, in_rmode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag,
           out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/unum4_pack_stream.sv
// Streaming unum4 pack unit: rounds an (exponent, two's-complement mantissa)
// pair to the precision its exponent leaves free, renormalises, then packs
// {exp bits, mantissa field, exponent size}. Saturates on overflow, flushes
// on underflow. Three lock-step pipeline stages with a global stall.
module unum4_pack_stream #(
  parameter int DATA_W    = 32,
  parameter int EXP_SZ_W  = 4,
  parameter int EXP_MAX_W = 16,
  parameter int MAN_MAX_W = 29,
  parameter int EXTRA     = 3,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  unum4_pack_stream_if.slave bus
);

  localparam int ES_MAX   = 2**EXP_SZ_W - 1;
  localparam int IN_W     = MAN_MAX_W + EXTRA;
  localparam int XW       = EXP_MAX_W + 1;
  localparam int ESW      = $clog2(XW + 1);
  localparam int SHW      = $clog2(DATA_W + 1);
  localparam int SAT_MF_W = DATA_W - EXP_SZ_W - ES_MAX;

  typedef struct packed {
    logic             valid;
    logic             zero;
    logic [1:0]       rmode;
    logic [TAG_W-1:0] tag;
    logic [ESW-1:0]   es;
    logic [EXP_MAX_W-1:0] exp;
    logic [IN_W-1:0]  mant;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             zero;
    logic             inexact;
    logic [TAG_W-1:0] tag;
    logic [ESW-1:0]   es;
    logic [XW-1:0]    exp;
    logic [IN_W-1:0]  mant;
  } s2_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              overflow;
    logic              underflow;
    logic              inexact;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic en;

  logic [ESW:0]    rnd_sh;
  logic [IN_W-1:0] low_mask;
  logic [IN_W-1:0] trunc;
  logic [IN_W:0]   sum;
  logic            lsb, g, st, inc;
  logic            pos_carry, neg_renorm;
  logic [XW-1:0]   exp_x, exp_r;
  logic [IN_W-1:0] mant_r;

  logic [SHW-1:0]    pk_sh;
  logic [ESW:0]      mf_sh;
  logic [IN_W-2:0]   mf;
  logic [DATA_W-1:0] packed_word;

  // Width of the smallest two's-complement field holding e (zero needs none).
  function automatic logic [ESW-1:0] es_of(input logic [XW-1:0] e);
    logic [XW-1:0]  mag;
    logic [ESW-1:0] w;
    mag = e[XW-1] ? ~e : e;
    w   = '0;
    if (e != '0) begin
      w = ESW'(1);
      for (int i = 0; i < XW-1; i++) begin
        if (mag[i]) w = ESW'(i + 2);
      end
    end
    return w;
  endfunction

  assign en           = ~s3_q.valid | bus.out_ready;
  assign bus.in_ready = en;

  // Stage 1: capture the beat, size its exponent and flag a zero mantissa
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.valid = bus.in_valid;
      s1_d.zero  = (bus.in_mant == '0);
      s1_d.rmode = bus.in_rmode;
      s1_d.tag   = bus.in_tag;
      s1_d.es    = es_of({bus.in_exp[EXP_MAX_W-1], bus.in_exp});
      s1_d.exp   = bus.in_exp;
      s1_d.mant  = bus.in_mant;
    end
  end

  // Stage 2: round at the first bit the exponent field displaces, then renormalise
  always_comb begin
    rnd_sh   = (ESW+1)'(EXTRA) + (ESW+1)'(s1_q.es);
    low_mask = (IN_W'(1) << rnd_sh) - IN_W'(1);
    lsb      = |(s1_q.mant & (low_mask + IN_W'(1)));
    g        = |(s1_q.mant & (low_mask & ~(low_mask >> 1)));
    st       = |(s1_q.mant & (low_mask >> 1));
    case (s1_q.rmode)
      2'd0:    inc = g & (st | lsb);
      2'd1:    inc = (g | st) & s1_q.mant[IN_W-1];
      2'd2:    inc = g | st;
      default: inc = 1'b0;
    endcase
    trunc      = s1_q.mant & ~low_mask;
    sum        = {trunc[IN_W-1], trunc} + ((IN_W+1)'(inc) << rnd_sh);
    pos_carry  = ~sum[IN_W] & sum[IN_W-1];
    neg_renorm = sum[IN_W] & sum[IN_W-1] & sum[IN_W-2];
    exp_x      = {s1_q.exp[EXP_MAX_W-1], s1_q.exp};
    exp_r      = exp_x;
    mant_r     = sum[IN_W-1:0];
    if (pos_carry) begin
      mant_r = IN_W'(1) << (IN_W - 2);
      exp_r  = exp_x + XW'(1);
    end else if (neg_renorm) begin
      mant_r = {sum[IN_W-2:0], 1'b0};
      exp_r  = exp_x - XW'(1);
    end
    s2_d = s2_q;
    if (en) begin
      s2_d.valid   = s1_q.valid;
      s2_d.zero    = s1_q.zero;
      s2_d.inexact = g | st;
      s2_d.tag     = s1_q.tag;
      s2_d.es      = es_of(exp_r);
      s2_d.exp     = exp_r;
      s2_d.mant    = mant_r;
    end
  end

  // Stage 3: range checks, then pack or substitute the saturated/flushed word
  always_comb begin
    pk_sh       = SHW'(DATA_W) - SHW'(s2_q.es);
    mf_sh       = (ESW+1)'(EXTRA) + (ESW+1)'(s2_q.es);
    mf          = s2_q.mant[IN_W-2:0] >> mf_sh;
    packed_word = (DATA_W'(s2_q.exp) << pk_sh)
                | (DATA_W'(mf) << EXP_SZ_W)
                | DATA_W'(s2_q.es[EXP_SZ_W-1:0]);
    s3_d = s3_q;
    if (en) begin
      s3_d.valid     = s2_q.valid;
      s3_d.tag       = s2_q.tag;
      s3_d.data      = packed_word;
      s3_d.overflow  = 1'b0;
      s3_d.underflow = 1'b0;
      s3_d.inexact   = s2_q.inexact;
      if (s2_q.zero) begin
        s3_d.data    = '0;
        s3_d.inexact = 1'b0;
      end else if (s2_q.es > ESW'(ES_MAX)) begin
        s3_d.inexact = 1'b1;
        if (!s2_q.exp[XW-1]) begin
          s3_d.overflow = 1'b1;
          s3_d.data     = {1'b0, {(ES_MAX-1){1'b1}},
                           {SAT_MF_W{~s2_q.mant[IN_W-1]}}, EXP_SZ_W'(ES_MAX)};
        end else begin
          s3_d.underflow = 1'b1;
          s3_d.data      = '0;
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.out_valid     = s3_q.valid;
  assign bus.out_data      = s3_q.data;
  assign bus.out_tag       = s3_q.tag;
  assign bus.out_overflow  = s3_q.overflow;
  assign bus.out_underflow = s3_q.underflow;
  assign bus.out_inexact   = s3_q.inexact;

endmodule

// File: tb/tb_unum4_pack_stream.sv
// Scoreboard bench for unum4_pack_stream: directed beats with known words,
// backpressure and reset-in-flight scenarios, then randomized traffic
// checked against an arithmetic reference model.
module tb_unum4_pack_stream;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  unum4_pack_stream_if bus ();

  unum4_pack_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        ov;
    logic        un;
    logic        ix;
  } beat_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  bit    rand_ready = 1'b0;

  function automatic beat_t mk(logic [31:0] d, logic [3:0] t, logic ov, logic un, logic ix);
    beat_t b;
    b.data = d; b.tag = t; b.ov = ov; b.un = un; b.ix = ix;
    return b;
  endfunction

  // Smallest two's-complement width that holds e; zero needs none
  function automatic int es_of(longint e);
    if (e == 0) return 0;
    for (int w = 1; w < 63; w++) begin
      if (e >= -(longint'(1) << (w - 1)) && e < (longint'(1) << (w - 1))) return w;
    end
    return 63;
  endfunction

  // Reference: value = m * 2^e, quantised to the grid the exponent leaves room for
  function automatic beat_t model(logic [31:0] mant, logic [15:0] ein, logic [1:0] rm, logic [3:0] tag);
    beat_t  b;
    longint m, e, p, q, rem, r;
    int     es;
    bit     up;
    b = mk(32'h0, tag, 1'b0, 1'b0, 1'b0);
    m = longint'($signed(mant));
    e = longint'($signed(ein));
    if (m == 0) return b;
    es  = es_of(e);
    p   = longint'(1) << (3 + es);
    q   = m >>> (3 + es);
    rem = m - q * p;
    b.ix = (rem != 0);
    case (rm)
      2'd0:    up = (rem > p / 2) || (rem == p / 2 && q[0]);
      2'd1:    up = (rem != 0) && (m < 0);
      2'd2:    up = (rem != 0);
      default: up = 1'b0;
    endcase
    r = (q + longint'(up)) * p;
    if (r == (longint'(1) << 31)) begin
      r = longint'(1) << 30;
      e = e + 1;
    end else if (r == -(longint'(1) << 30)) begin
      r = -(longint'(1) << 31);
      e = e - 1;
    end
    es = es_of(e);
    if (es > 15) begin
      b.ix = 1'b1;
      if (e > 0) begin
        b.ov   = 1'b1;
        b.data = {1'b0, 14'h3FFF, (m < 0) ? 13'h0000 : 13'h1FFF, 4'hF};
      end else begin
        b.un   = 1'b1;
        b.data = 32'h0;
      end
    end else begin
      b.data = 32'(((e & ((longint'(1) << es) - 1)) << (32 - es))
                 | (((r >>> (3 + es)) & ((longint'(1) << (28 - es)) - 1)) << 4)
                 | longint'(es));
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input beat_t act, input beat_t expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got data=%h tag=%0d ov=%0b un=%0b ix=%0b, expected data=%h tag=%0d ov=%0b un=%0b ix=%0b",
               name, act.data, act.tag, act.ov, act.un, act.ix,
               expv.data, expv.tag, expv.ov, expv.un, expv.ix);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  // Offer one beat and wait (bounded) until the unit takes it
  task automatic applyStimulus(input logic [31:0] mant, input logic [15:0] e,
                               input logic [1:0] rm, input logic [3:0] tag, input beat_t expv);
    int waited;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mant  = mant;
    bus.in_exp   = e;
    bus.in_rmode = rm;
    bus.in_tag   = tag;
    #1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at %b, expected 1 within 100 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back(expv);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic sendRandom(input logic [3:0] tag);
    logic [31:0] m;
    logic [15:0] e;
    logic [1:0]  rm;
    logic [15:0] edges [8] = '{16'h3FFF, 16'h4000, 16'hC000, 16'hBFFF,
                               16'h7FFF, 16'h8000, 16'h3FFE, 16'hC001};
    case ($urandom_range(0, 9))
      0:       m = 32'h0;
      1:       m = 32'h7FFFFFF0 | 32'($urandom_range(0, 15));
      2:       m = 32'hBFFFFFF0 | 32'($urandom_range(0, 15));
      3:       m = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 30'($urandom)} & 32'hFFFF0000;
      default: m = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 30'($urandom)};
    endcase
    case ($urandom_range(0, 5))
      0:       e = edges[$urandom_range(0, 7)];
      1:       e = 16'($urandom);
      default: e = 16'(int'($urandom_range(0, 40)) - 20);
    endcase
    rm = 2'($urandom_range(0, 3));
    applyStimulus(m, e, rm, tag, model(m, e, rm, tag));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: %0d beats still outstanding, expected 0", name, sb.size());
    end
  endtask

  // Downstream ready: randomized when enabled, otherwise left to the main sequence
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop and compare on every transfer, and check held outputs under stall
  initial begin
    beat_t act, held;
    bit    held_valid;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held_valid = 1'b0;
        continue;
      end
      act = mk(bus.out_data, bus.out_tag, bus.out_overflow, bus.out_underflow, bus.out_inexact);
      if (held_valid && bus.out_valid) checkOutput("hold_stable", act, held);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got data=%h tag=%0d, expected no beat", bus.out_data, bus.out_tag);
        end else begin
          checkOutput("beat", act, sb.pop_front());
        end
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held = act;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    logic [31:0] d_mant [12] = '{32'h40000000, 32'h40000000, 32'h40000004, 32'h4000000C,
                                 32'h4000000C, 32'h40000000, 32'h00000000, 32'h40000000,
                                 32'h40000000, 32'h80000000, 32'h7FFFFFFF, 32'hBFFFFFFF};
    logic [15:0] d_exp  [12] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000,
                                 16'h0000, 16'h7FFF, 16'h1234, 16'hBFFF,
                                 16'hC000, 16'h7FFF, 16'h0000, 16'h0000};
    logic [1:0]  d_rm   [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [31:0] d_data [12] = '{32'h80000000, 32'h60000002, 32'h80000000, 32'h80000020,
                                 32'h80000010, 32'h7FFFFFFF, 32'h00000000, 32'h00000000,
                                 32'h8001000F, 32'h7FFE000F, 32'h60000002, 32'h80000001};
    logic [2:0]  d_flag [12] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b101,
                                 3'b000, 3'b011, 3'b000, 3'b101, 3'b001, 3'b001};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_rmode  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkBit("reset_out_valid", bus.out_valid, 1'b0);
    checkBit("reset_in_ready", bus.in_ready, 1'b1);
    checkOutput("reset_outputs",
                mk(bus.out_data, bus.out_tag, bus.out_overflow, bus.out_underflow, bus.out_inexact),
                mk(32'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    $display("[TB] directed beats");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(d_mant[i], d_exp[i], d_rm[i], 4'(i),
                    mk(d_data[i], 4'(i), d_flag[i][2], d_flag[i][1], d_flag[i][0]));
    end
    idle(1);
    drain("drain_directed");

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) sendRandom(4'(i));
        idle(1);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (bus.out_valid !== 1'b1 && n < 50) begin
          @(negedge clk);
          #1;
          n++;
        end
        checkBit("stall_out_valid", bus.out_valid, 1'b1);
        repeat (4) begin
          @(negedge clk);
          #1;
          checkBit("stall_in_ready", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    $display("[TB] reset with beats in flight");
    applyStimulus(32'h40000000, 16'h0003, 2'd0, 4'hA, mk(32'h0, 4'hA, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'h80000000, 16'h0005, 2'd0, 4'hB, mk(32'h0, 4'hB, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkBit("reset_flush_valid", bus.out_valid, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      checkBit("no_stale_beat", bus.out_valid, 1'b0);
    end

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sendRandom(4'(n));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    drain("drain_random");
    rand_ready = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
